// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states and default sizing.
package mult_div_unit_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULT   = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit <-> mult/div unit signal bundle; master is the control unit.
interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start_mult, start_div, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per enable pulse.
module restoring_div_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last_step
);
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [CNT_W-1:0] cnt;

  // rem < dvsr always holds, so the shifted remainder minus the divisor fits WIDTH+1 signed bits
  assign rem_sh    = {rem, quo[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, dvsr};
  assign last_step = enable && (cnt == CNT_W'(WIDTH - 1));
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      dvsr <= '0;
      quo  <= '0;
      rem  <= '0;
      cnt  <= '0;
    end else if (load) begin
      dvsr <= divisor;
      quo  <= dividend;
      rem  <= '0;
      cnt  <= '0;
    end else if (enable) begin
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit with hi/lo result registers.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  state_t state, state_nxt;

  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   mcand_x;
  logic [WIDTH-1:0] mcand, mul;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, div_zero_q;
  logic             is_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem, quo_fix, rem_fix;
  logic             div_load, div_last;

  // Magnitudes are unsigned, so -2^(W-1) maps cleanly onto 2^(W-1)
  assign a_mag    = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag    = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign div_load = (state == ST_IDLE) && !bus.start_mult && bus.start_div && (bus.b != '0);
  assign quo_fix  = (a_neg ^ b_neg) ? -quo : quo;
  assign rem_fix  = a_neg ? -rem : rem;

  restoring_div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .enable    (state == ST_DIV),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem),
    .last_step (div_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.start_mult)     state_nxt = ST_MULT;
        else if (bus.start_div) state_nxt = (bus.b != '0) ? ST_DIV : ST_FINISH;
      end
      ST_MULT:   if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FINISH;
      ST_DIV:    if (div_last) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Accumulator carries one guard bit so subtracting -2^(W-1) cannot overflow
  assign mcand_x = {mcand[WIDTH-1], mcand};

  always_comb begin
    acc_sum = acc;
    unique case ({mul[0], q_m1})
      2'b01:   acc_sum = acc + mcand_x;
      2'b10:   acc_sum = acc - mcand_x;
      default: acc_sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      mcand      <= '0;
      mul        <= '0;
      q_m1       <= 1'b0;
      cnt        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      is_div     <= 1'b0;
      a_neg      <= 1'b0;
      b_neg      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start_mult) begin
            acc        <= '0;
            mcand      <= bus.a;
            mul        <= bus.b;
            q_m1       <= 1'b0;
            cnt        <= '0;
            is_div     <= 1'b0;
            div_zero_q <= 1'b0;
          end else if (bus.start_div) begin
            is_div     <= 1'b1;
            a_neg      <= bus.a[WIDTH-1];
            b_neg      <= bus.b[WIDTH-1];
            div_zero_q <= (bus.b == '0);
          end
        end
        ST_MULT: begin
          acc  <= {acc_sum[WIDTH], acc_sum[WIDTH:1]};
          mul  <= {acc_sum[0], mul[WIDTH-1:1]};
          q_m1 <= mul[0];
          cnt  <= cnt + 1'b1;
        end
        ST_FINISH: begin
          done_q <= 1'b1;
          cnt    <= '0;
          if (!div_zero_q) begin
            hi_q <= is_div ? rem_fix : acc[WIDTH-1:0];
            lo_q <= is_div ? quo_fix : mul;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.busy     = (state == ST_MULT) || (state == ST_DIV);
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops against a cycle-level reference model.
module tb_mult_div_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  bit   chk_en;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted op completes 33 edges later; a zero divisor completes after 1
  int          m_left;
  bit          m_busy_op;
  bit          m_done;
  bit          m_dz;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;

  function automatic logic [63:0] mulRef(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  function automatic logic [63:0] divRef(input logic [31:0] x, input logic [31:0] y);
    longint q, r;
    if (y == 32'd0) return 64'd0;
    q = longint'($signed(x)) / longint'($signed(y));
    r = longint'($signed(x)) % longint'($signed(y));
    return {r[31:0], q[31:0]};
  endfunction

  initial begin
    m_left = 0; m_busy_op = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_res = '0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0; m_busy_op <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          if (!m_dz) begin
            m_hi <= m_res[63:32];
            m_lo <= m_res[31:0];
          end
        end
      end else if (bus.start_mult) begin
        m_res <= mulRef(bus.a, bus.b); m_left <= 33; m_busy_op <= 1'b1; m_dz <= 1'b0;
      end else if (bus.start_div) begin
        m_res     <= divRef(bus.a, bus.b);
        m_dz      <= (bus.b == 32'd0);
        m_left    <= (bus.b == 32'd0) ? 1 : 33;
        m_busy_op <= (bus.b != 32'd0);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("hi", bus.hi, m_hi);
      checkOutput("lo", bus.lo, m_lo);
      checkOutput("busy", {31'd0, bus.busy}, {31'd0, (m_busy_op && m_left >= 2)});
      checkOutput("done", {31'd0, bus.done}, {31'd0, m_done});
      checkOutput("div_zero", {31'd0, bus.div_zero}, {31'd0, m_dz});
    end
  end

  task automatic applyStimulus(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b);
    bus.start_mult = sm;
    bus.start_div  = sd;
    bus.a          = a;
    bus.b          = b;
    @(posedge clk);
    #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
  endtask

  // Returns edges from acceptance to the cycle done is seen, and how many of those cycles had busy high
  task automatic waitDone(input bit inject, output int lat, output int bcnt);
    bit seen;
    seen = 0;
    lat  = 0;
    bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (inject && i == 3) begin
        bus.start_div = 1'b1; bus.start_mult = 1'b1; bus.a = $urandom; bus.b = $urandom;
      end
      if (inject && i == 4) begin
        bus.start_div = 1'b0; bus.start_mult = 1'b0;
      end
      if (bus.done) begin
        seen = 1; lat = i; break;
      end
      if (bus.busy) bcnt++;
    end
    if (!seen) begin
      n_checks++;
      $display("[TB] FAIL done_timeout: got no done within 60 cycles, expected done at %0t", $time);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, bcnt, dcnt, gap;
    bit kind;
    logic [31:0] ra, rb;
    n_checks = 0; n_pass = 0; chk_en = 0;
    reset = 1'b1;
    bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1;
    @(negedge clk);
    checkOutput("reset_hi", bus.hi, 32'h0);
    checkOutput("reset_lo", bus.lo, 32'h0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus.done}, 32'd0);

    $display("[TB] T1 mult 7 * -3");
    applyStimulus(1, 0, 32'd7, -32'sd3);
    waitDone(0, lat, bcnt);
    checkOutput("t1_latency", 32'(lat), 32'd33);
    checkOutput("t1_busy_cycles", 32'(bcnt), 32'd32);
    checkOutput("t1_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("t1_lo", bus.lo, 32'hFFFF_FFEB);

    $display("[TB] T2 mult extremes, back-to-back from the done cycle");
    applyStimulus(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    waitDone(0, lat, bcnt);
    checkOutput("t2a_latency", 32'(lat), 32'd33);
    checkOutput("t2a_hi", bus.hi, 32'h3FFF_FFFF);
    checkOutput("t2a_lo", bus.lo, 32'h0000_0001);
    applyStimulus(1, 0, 32'h8000_0000, 32'h8000_0000);
    waitDone(0, lat, bcnt);
    checkOutput("t2b_hi", bus.hi, 32'h4000_0000);
    checkOutput("t2b_lo", bus.lo, 32'h0000_0000);

    $display("[TB] T3 signed divide");
    applyStimulus(0, 1, -32'sd7, 32'd2);
    waitDone(0, lat, bcnt);
    checkOutput("t3a_latency", 32'(lat), 32'd33);
    checkOutput("t3a_lo", bus.lo, 32'hFFFF_FFFD);
    checkOutput("t3a_hi", bus.hi, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 32'd7, -32'sd2);
    waitDone(0, lat, bcnt);
    checkOutput("t3b_lo", bus.lo, 32'hFFFF_FFFD);
    checkOutput("t3b_hi", bus.hi, 32'h0000_0001);

    $display("[TB] T4 divide by zero");
    applyStimulus(0, 1, 32'd100, 32'd0);
    waitDone(0, lat, bcnt);
    checkOutput("t4_latency", 32'(lat), 32'd1);
    checkOutput("t4_busy_cycles", 32'(bcnt), 32'd0);
    checkOutput("t4_div_zero", {31'd0, bus.div_zero}, 32'd1);
    checkOutput("t4_hi_kept", bus.hi, 32'h0000_0001);
    checkOutput("t4_lo_kept", bus.lo, 32'hFFFF_FFFD);
    repeat (4) @(negedge clk);
    checkOutput("t4_dz_sticky", {31'd0, bus.div_zero}, 32'd1);
    applyStimulus(1, 0, 32'd3, 32'd4);
    checkOutput("t4_dz_cleared", {31'd0, bus.div_zero}, 32'd0);
    waitDone(0, lat, bcnt);
    checkOutput("t4_mult_lo", bus.lo, 32'd12);

    $display("[TB] T5 most-negative / -1");
    applyStimulus(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(0, lat, bcnt);
    checkOutput("t5_lo", bus.lo, 32'h8000_0000);
    checkOutput("t5_hi", bus.hi, 32'h0000_0000);
    checkOutput("t5_div_zero", {31'd0, bus.div_zero}, 32'd0);

    $display("[TB] T6 reset mid-operation, ignored starts, simultaneous starts");
    applyStimulus(1, 0, 32'd11, 32'd13);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("t6_hi", bus.hi, 32'h0);
    checkOutput("t6_lo", bus.lo, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    checkOutput("t6_no_done", 32'(dcnt), 32'd0);
    applyStimulus(1, 0, 32'd9, -32'sd4);
    waitDone(1, lat, bcnt);
    checkOutput("t6_busy_start_lo", bus.lo, 32'hFFFF_FFDC);
    checkOutput("t6_busy_start_hi", bus.hi, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 32'd6, 32'd5);
    waitDone(0, lat, bcnt);
    checkOutput("t6_both_lo", bus.lo, 32'd30);
    checkOutput("t6_both_hi", bus.hi, 32'd0);

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++) begin
      kind = 1'($urandom_range(0, 1));
      ra   = pickOperand();
      rb   = ($urandom_range(0, 7) == 0) ? 32'd0 : pickOperand();
      applyStimulus(!kind, kind, ra, rb);
      waitDone((!kind || rb != 32'd0) && ($urandom_range(0, 3) == 0), lat, bcnt);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
